// File: rtl/vdp_sprite_info_collect.sv
// Sprite info collection: per slot, reads Y/X/pattern/color/pattern bytes and emits one record.
// Latency: record strobed at the last dot of each 8-dot slot; no backpressure, locked to dot timing.
module vdp_sprite_info_collect #(
   parameter logic [8:0] START_X = 9'd256
) (
   input  logic        clk21m,
   input  logic        reset,
   input  logic [1:0]  dot_state,
   input  logic [2:0]  eight_dot_state,
   input  logic [8:0]  dot_counter_x,
   input  logic [8:0]  current_y,
   input  logic        reg_r1_sp_size,
   input  logic        reg_r1_sp_zoom,
   input  logic        sp_mode2,
   input  logic [9:0]  attribute_table_address,
   input  logic [5:0]  pattern_table_address,
   output logic [2:0]  current_render_sp,
   input  logic [4:0]  render_sp,
   input  logic [3:0]  render_sp_num,
   output logic [16:0] vram_a,
   input  logic [7:0]  vram_q,
   output logic        info_we,
   output logic [2:0]  info_index,
   output logic        info_active,
   output logic [7:0]  info_x,
   output logic [15:0] info_pattern,
   output logic [3:0]  info_color,
   output logic        info_ec,
   output logic        info_cc,
   output logic        info_ic
);

   typedef enum logic {IDLE, COLLECT} state_t;
   state_t state, state_nx;

   logic [2:0]  slot;
   logic [4:0]  n_r;
   logic [7:0]  y_r, x_r, p_r, col_r, left_r, right_r;
   logic [16:0] base_a, attr_n, col2_a, pat_left, pat_right, rd_addr;
   logic [4:0]  n_sel;
   logic [7:0]  d, l;
   logic        phase01, phase10, phase11, grp_end, start, active;

   assign phase01 = (dot_state == 2'b01);
   assign phase10 = (dot_state == 2'b10);
   assign phase11 = (dot_state == 2'b11);
   assign grp_end = phase10 && (eight_dot_state == 3'd7);
   assign start   = grp_end && (dot_counter_x[8:3] == (START_X[8:3] - 6'd1));
   // Counts above 8 compare as "all slots active" without extra clamping.
   assign active  = ({1'b0, slot} < render_sp_num);

   assign base_a = {attribute_table_address, 7'b0};
   assign n_sel  = (eight_dot_state == 3'd0) ? render_sp : n_r;
   assign attr_n = base_a + {10'b0, n_sel, 2'b00};
   assign d      = current_y[7:0] - y_r - 8'd1;
   assign l      = reg_r1_sp_zoom ? {1'b0, d[7:1]} : d;
   assign col2_a = base_a - 17'd512 + {8'b0, n_r, 4'b0} + {13'b0, l[3:0]};
   assign pat_left  = reg_r1_sp_size ? {pattern_table_address, p_r[7:2], 1'b0, l[3:0]}
                                     : {pattern_table_address, p_r, l[2:0]};
   assign pat_right = reg_r1_sp_size ? {pattern_table_address, p_r[7:2], 1'b1, l[3:0]}
                                     : {pattern_table_address, p_r, l[2:0]};

   always_comb begin
      rd_addr = attr_n;
      case (eight_dot_state)
         3'd1:    rd_addr = attr_n + 17'd1;
         3'd2:    rd_addr = attr_n + 17'd2;
         3'd3:    rd_addr = sp_mode2 ? col2_a : attr_n + 17'd3;
         3'd4:    rd_addr = pat_left;
         3'd5:    rd_addr = pat_right;
         default: rd_addr = attr_n;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = COLLECT;
         COLLECT: if (grp_end && slot == 3'd7) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk21m) begin
      if (reset) begin
         state             <= IDLE;
         slot              <= 3'd0;
         n_r               <= 5'd0;
         y_r               <= 8'd0;
         x_r               <= 8'd0;
         p_r               <= 8'd0;
         col_r             <= 8'd0;
         left_r            <= 8'd0;
         right_r           <= 8'd0;
         current_render_sp <= 3'd0;
         vram_a            <= 17'd0;
         info_we           <= 1'b0;
         info_index        <= 3'd0;
         info_active       <= 1'b0;
         info_x            <= 8'd0;
         info_pattern      <= 16'd0;
         info_color        <= 4'd0;
         info_ec           <= 1'b0;
         info_cc           <= 1'b0;
         info_ic           <= 1'b0;
      end else begin
         state   <= state_nx;
         info_we <= 1'b0;
         if (state == IDLE && start) begin
            slot              <= 3'd0;
            current_render_sp <= 3'd0;
         end
         if (state == COLLECT) begin
            if (active && phase01 && eight_dot_state <= 3'd5) begin
               vram_a <= rd_addr;
               if (eight_dot_state == 3'd0) n_r <= render_sp;
            end
            if (active && phase10) begin
               case (eight_dot_state)
                  3'd0:    y_r     <= vram_q;
                  3'd1:    x_r     <= vram_q;
                  3'd2:    p_r     <= vram_q;
                  3'd3:    col_r   <= vram_q;
                  3'd4:    left_r  <= vram_q;
                  3'd5:    right_r <= vram_q;
                  default: ;
               endcase
            end
            // Registered one dot phase early so the strobe coincides with dot_state 10.
            if (phase11 && eight_dot_state == 3'd7) begin
               info_we      <= 1'b1;
               info_index   <= slot;
               info_active  <= active;
               info_x       <= active ? x_r : 8'd0;
               info_pattern <= active ? {left_r, (reg_r1_sp_size ? right_r : 8'h00)} : 16'd0;
               info_color   <= active ? col_r[3:0] : 4'd0;
               info_ec      <= active & col_r[7];
               info_cc      <= active & sp_mode2 & col_r[6];
               info_ic      <= active & sp_mode2 & col_r[5];
            end
            if (grp_end) begin
               slot              <= slot + 3'd1;
               current_render_sp <= slot + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vdp_sprite_info_collect.sv
// Directed bench: free-running dot timing, behavioural VRAM, scoreboard of reads and info records.
module tb_vdp_sprite_info_collect;

   logic        clk21m = 1'b0;
   logic        reset;
   logic [1:0]  dot_state;
   logic [2:0]  eight_dot_state;
   logic [8:0]  dot_counter_x;
   logic [8:0]  current_y;
   logic        reg_r1_sp_size, reg_r1_sp_zoom, sp_mode2;
   logic [9:0]  attribute_table_address;
   logic [5:0]  pattern_table_address;
   logic [2:0]  current_render_sp;
   logic [4:0]  render_sp;
   logic [3:0]  render_sp_num;
   logic [16:0] vram_a;
   logic [7:0]  vram_q;
   logic        info_we, info_active, info_ec, info_cc, info_ic;
   logic [2:0]  info_index;
   logic [7:0]  info_x;
   logic [15:0] info_pattern;
   logic [3:0]  info_color;

   typedef struct packed {
      logic [2:0]  idx;
      logic        act;
      logic [7:0]  x;
      logic [15:0] pat;
      logic [3:0]  col;
      logic        ec, cc, ic;
   } rec_t;

   logic [7:0] mem [0:131071];
   logic [4:0] sp_tab [0:7];
   rec_t       rec_q[$];
   int         crs_q[$];
   int         cyc_q[$];
   logic [16:0] vlog[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   assign vram_q    = mem[vram_a];
   assign render_sp = sp_tab[current_render_sp];

   vdp_sprite_info_collect #(.START_X(9'd256)) dut (
      .clk21m(clk21m), .reset(reset), .dot_state(dot_state),
      .eight_dot_state(eight_dot_state), .dot_counter_x(dot_counter_x),
      .current_y(current_y), .reg_r1_sp_size(reg_r1_sp_size),
      .reg_r1_sp_zoom(reg_r1_sp_zoom), .sp_mode2(sp_mode2),
      .attribute_table_address(attribute_table_address),
      .pattern_table_address(pattern_table_address),
      .current_render_sp(current_render_sp), .render_sp(render_sp),
      .render_sp_num(render_sp_num), .vram_a(vram_a), .vram_q(vram_q),
      .info_we(info_we), .info_index(info_index), .info_active(info_active),
      .info_x(info_x), .info_pattern(info_pattern), .info_color(info_color),
      .info_ec(info_ec), .info_cc(info_cc), .info_ic(info_ic)
   );

   initial forever #5 clk21m = ~clk21m;

   // Dot timing: 4 clocks per dot, 342 dots per line.
   initial begin
      dot_state = 2'b00;
      dot_counter_x = 9'd0;
      eight_dot_state = 3'd0;
      forever begin
         @(posedge clk21m);
         cyc = cyc + 1;
         #1;
         case (dot_state)
            2'b00: dot_state = 2'b01;
            2'b01: dot_state = 2'b11;
            2'b11: dot_state = 2'b10;
            default: begin
               dot_state = 2'b00;
               dot_counter_x = (dot_counter_x == 9'd341) ? 9'd0 : dot_counter_x + 9'd1;
               eight_dot_state = dot_counter_x[2:0];
            end
         endcase
      end
   end

   initial forever begin
      @(negedge clk21m);
      if (dot_state == 2'b10 && dot_counter_x >= 9'd256 && dot_counter_x < 9'd320 &&
          eight_dot_state <= 3'd5)
         vlog.push_back(vram_a);
      if (info_we) begin
         rec_q.push_back({info_index, info_active, info_x, info_pattern, info_color,
                          info_ec, info_cc, info_ic});
         crs_q.push_back(int'(current_render_sp));
         cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic rec_t mk(input logic [2:0] idx, input logic act, input logic [7:0] x,
                               input logic [15:0] pat, input logic [3:0] col,
                               input logic ec, input logic cc, input logic ic);
      return {idx, act, x, pat, col, ec, cc, ic};
   endfunction

   task automatic wait_dcx(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk21m);
         n++;
      end while (!(int'(dot_counter_x) == target && dot_state == 2'b00) && n < 3000);
      check($sformatf("wait_dcx_%0d", target), n < 3000, 1);
   endtask

   task automatic clear_logs();
      rec_q.delete();
      crs_q.delete();
      cyc_q.delete();
      vlog.delete();
   endtask

   task automatic run_window();
      wait_dcx(200);
      clear_logs();
      wait_dcx(330);
   endtask

   task automatic cfg(input logic m2, input logic sz, input logic zm, input logic [9:0] at,
                      input logic [5:0] pt, input logic [8:0] cy, input logic [3:0] num);
      sp_mode2 = m2;
      reg_r1_sp_size = sz;
      reg_r1_sp_zoom = zm;
      attribute_table_address = at;
      pattern_table_address = pt;
      current_y = cy;
      render_sp_num = num;
   endtask

   task automatic chk_reads(input string tag, input int s, input logic [16:0] a0,
                            input logic [16:0] a1, input logic [16:0] a2, input logic [16:0] a3,
                            input logic [16:0] a4, input logic [16:0] a5);
      logic [16:0] ev [0:5];
      ev[0] = a0; ev[1] = a1; ev[2] = a2; ev[3] = a3; ev[4] = a4; ev[5] = a5;
      for (int k = 0; k < 6; k++)
         check($sformatf("%s_rd%0d", tag, k),
               (s * 6 + k < vlog.size()) ? vlog[s * 6 + k] : 17'h1FFFF, ev[k]);
   endtask

   // Every slot strobes once, 8 dots apart, while current_render_sp still names it.
   task automatic chk_strobes(input string tag);
      check({tag, "_nrec"}, rec_q.size(), 8);
      for (int i = 0; i < rec_q.size(); i++)
         check($sformatf("%s_crs%0d", tag, i), crs_q[i], i);
      for (int i = 1; i < cyc_q.size(); i++)
         check($sformatf("%s_gap%0d", tag, i), cyc_q[i] - cyc_q[i - 1], 32);
   endtask

   task automatic chk_idle_tail(input string tag, input int first, input logic [16:0] held);
      int bad;
      bad = 0;
      for (int i = first; i < vlog.size(); i++)
         if (vlog[i] !== held) bad++;
      check({tag, "_held_a"}, bad, 0);
      check({tag, "_nlog"}, vlog.size(), 48);
      for (int s = 8 - (48 - first) / 6; s < 8; s++)
         check($sformatf("%s_slot%0d", tag, s),
               (s < rec_q.size()) ? rec_q[s] : '1, mk(3'(s), 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      reset = 1'b1;
      cfg(0, 0, 0, 10'd0, 6'd0, 9'd0, 4'd0);
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) sp_tab[i] = 5'd0;
      repeat (6) @(posedge clk21m);
      #2;
      check("rst_vram_a", vram_a, 0);
      check("rst_crs", current_render_sp, 0);
      check("rst_info", {info_we, info_index, info_active, info_x, info_pattern, info_color,
                         info_ec, info_cc, info_ic}, 0);
      reset = 1'b0;

      // A: mode 2, 16x16, one sprite (n=3), Y=45 on line 50 -> L=4.
      cfg(1, 1, 0, 10'h03C, 6'h07, 9'd50, 4'd1);
      sp_tab[0] = 5'd3;
      mem[17'h1E0C] = 8'd45; mem[17'h1E0D] = 8'h80; mem[17'h1E0E] = 8'h25;
      mem[17'h1C34] = 8'h6C; mem[17'h3924] = 8'hA5; mem[17'h3934] = 8'h5A;
      run_window();
      chk_reads("A", 0, 17'h1E0C, 17'h1E0D, 17'h1E0E, 17'h1C34, 17'h3924, 17'h3934);
      check("A_slot0", (rec_q.size() > 0) ? rec_q[0] : '1,
            mk(0, 1, 8'h80, 16'hA55A, 4'hC, 0, 1, 1));
      chk_idle_tail("A", 6, 17'h3934);
      chk_strobes("A");

      // B: mode 1, 8x8, two sprites; second wraps D to 0xFF and masks CC/IC.
      cfg(0, 0, 0, 10'h03C, 6'h07, 9'd12, 4'd2);
      sp_tab[0] = 5'd5; sp_tab[1] = 5'd6;
      mem[17'h1E14] = 8'd9;  mem[17'h1E15] = 8'h10; mem[17'h1E16] = 8'h41; mem[17'h1E17] = 8'h8F;
      mem[17'h1E18] = 8'd12; mem[17'h1E19] = 8'h20; mem[17'h1E1A] = 8'h00; mem[17'h1E1B] = 8'hE3;
      mem[17'h3A0A] = 8'hC3; mem[17'h3807] = 8'h81;
      run_window();
      chk_reads("B", 0, 17'h1E14, 17'h1E15, 17'h1E16, 17'h1E17, 17'h3A0A, 17'h3A0A);
      chk_reads("B", 1, 17'h1E18, 17'h1E19, 17'h1E1A, 17'h1E1B, 17'h3807, 17'h3807);
      check("B_slot0", (rec_q.size() > 0) ? rec_q[0] : '1, mk(0, 1, 8'h10, 16'hC300, 4'hF, 1, 0, 0));
      check("B_slot1", (rec_q.size() > 1) ? rec_q[1] : '1, mk(1, 1, 8'h20, 16'h8100, 4'h3, 1, 0, 0));
      chk_idle_tail("B", 12, 17'h3807);

      // C: zoom, 16x16, Y=0 on line 21 -> L=10; count 9 behaves as 8.
      cfg(0, 1, 1, 10'h000, 6'h07, 9'd21, 4'd9);
      sp_tab[0] = 5'd0; sp_tab[1] = 5'd0;
      mem[17'h0] = 8'd0; mem[17'h1] = 8'h33; mem[17'h2] = 8'h04; mem[17'h3] = 8'h07;
      mem[17'h382A] = 8'h11; mem[17'h383A] = 8'h22;
      run_window();
      chk_reads("C", 0, 17'h0, 17'h1, 17'h2, 17'h3, 17'h382A, 17'h383A);
      chk_reads("C", 7, 17'h0, 17'h1, 17'h2, 17'h3, 17'h382A, 17'h383A);
      for (int s = 0; s < 8; s++)
         check($sformatf("C_slot%0d", s), (s < rec_q.size()) ? rec_q[s] : '1,
               mk(3'(s), 1, 8'h33, 16'h1122, 4'h7, 0, 0, 0));
      chk_strobes("C");

      // D: no sprites on the line.
      cfg(0, 1, 1, 10'h000, 6'h07, 9'd21, 4'd0);
      run_window();
      chk_idle_tail("D", 0, 17'h383A);
      chk_strobes("D");

      // E: reset in slot 3 aborts; following window runs normally.
      cfg(1, 1, 0, 10'h03C, 6'h07, 9'd50, 4'd1);
      sp_tab[0] = 5'd3;
      wait_dcx(200);
      clear_logs();
      wait_dcx(256 + 26);
      @(posedge clk21m);
      #1 reset = 1'b1;
      @(posedge clk21m);
      #2;
      check("E_rst_vram_a", vram_a, 0);
      check("E_rst_crs", current_render_sp, 0);
      check("E_rst_info", {info_we, info_index, info_active, info_x, info_pattern, info_color,
                           info_ec, info_cc, info_ic}, 0);
      reset = 1'b0;
      wait_dcx(330);
      check("E_abort_nrec", rec_q.size(), 3);
      run_window();
      chk_reads("E", 0, 17'h1E0C, 17'h1E0D, 17'h1E0E, 17'h1C34, 17'h3924, 17'h3934);
      check("E_slot0", (rec_q.size() > 0) ? rec_q[0] : '1,
            mk(0, 1, 8'h80, 16'hA55A, 4'hC, 0, 1, 1));
      chk_strobes("E");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
